instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 128 ++++++++++++
 tb/tb_instr_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Assembles a little-endian byte stream into instruction words and writes them to instruction memory.
// Write issues 1 cycle after the last byte of a word; byte_ready is low outside RECV, so one word per BPW+1 cycles.
module instr_loader #(
    parameter int ADDRESS_WIDTH     = 8,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDRESS_WIDTH:0]       num_words,
    input  logic                         abort,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         byte_ready,
    output logic                         WE,
    output logic [ADDRESS_WIDTH-1:0]     WA,
    output logic [INSTRUCTION_WIDTH-1:0] WD,
    output logic                         busy,
    output logic                         done
);

    localparam int BPW = INSTRUCTION_WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t                       state;
    logic [CW-1:0]                byte_cnt;
    logic [ADDRESS_WIDTH-1:0]     addr;
    logic [ADDRESS_WIDTH:0]       words_total;
    logic [INSTRUCTION_WIDTH-1:0] word;
    logic [INSTRUCTION_WIDTH-1:0] word_nxt;
    logic                         accept;
    logic                         last_byte;
    logic                         last_word;

    assign accept    = byte_valid && byte_ready;
    assign last_byte = (byte_cnt == CW'(BPW - 1));
    // Compared one bit wider than the address so a full 2**ADDRESS_WIDTH session ends at the top word without wrapping.
    assign last_word = (({1'b0, addr} + {{ADDRESS_WIDTH{1'b0}}, 1'b1}) == words_total);

    always_comb begin
        word_nxt = word;
        if (accept) begin
            word_nxt[8*byte_cnt +: 8] = byte_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            addr        <= '0;
            words_total <= '0;
            word        <= '0;
            byte_ready  <= 1'b0;
            WE          <= 1'b0;
            WA          <= '0;
            WD          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            WE   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        words_total <= num_words;
                        addr        <= '0;
                        byte_cnt    <= '0;
                        busy        <= 1'b1;
                        if (num_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RECV;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    // Abort wins over a coincident byte, so the partial word is simply dropped.
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        byte_ready <= 1'b0;
                        byte_cnt   <= '0;
                    end else if (accept) begin
                        word <= word_nxt;
                        if (last_byte) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            byte_cnt   <= '0;
                            WE         <= 1'b1;
                            WA         <= addr;
                            WD         <= word_nxt;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (last_word) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= RECV;
                        addr       <= addr + 1'b1;
                        byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: single-word vector table plus multi-word, gap, abort, zero-length and reset sequences.
module tb_instr_loader;

    localparam int AW = 8;
    localparam int IW = 32;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic [AW:0]   num_words  = '0;
    logic          abort      = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data  = '0;
    logic          byte_ready;
    logic          WE;
    logic [AW-1:0] WA;
    logic [IW-1:0] WD;
    logic          busy;
    logic          done;

    instr_loader #(.ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .WE(WE), .WA(WA), .WD(WD), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int            cyc       = 0;
    int            pass_cnt  = 0;
    int            total_cnt = 0;
    int            done_cnt  = 0;
    int            done_cyc  = 0;
    int            br_viol   = 0;
    logic [AW-1:0] q_wa[$];
    logic [IW-1:0] q_wd[$];
    int            q_cyc[$];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (WE) begin
            q_wa.push_back(WA);
            q_wd.push_back(WD);
            q_cyc.push_back(cyc);
            if (byte_ready) br_viol++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] wd;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic clear_log();
        q_wa.delete();
        q_wd.delete();
        q_cyc.delete();
        br_viol = 0;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_words = (AW+1)'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        tries      = 0;
        while (!byte_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 50) begin
            total_cnt++;
            $display("FAIL byte_accept: byte_ready stayed 0, expected 1 within 50 cycles");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", done_cnt - d0, 1);
    endtask

    task automatic run_three(input int gapmax);
        int d0;
        clear_log();
        d0 = done_cnt;
        do_start(3);
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++)
                send_byte(8'(16*w + k + 1), (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
        wait_done(d0);
        check("three_we_count", q_wa.size(), 3);
        if (q_wa.size() == 3) begin
            check("three_wa0", q_wa[0], 0);
            check("three_wa1", q_wa[1], 1);
            check("three_wa2", q_wa[2], 2);
            check("three_wd0", q_wd[0], 32'h04030201);
            check("three_wd1", q_wd[1], 32'h14131211);
            check("three_wd2", q_wd[2], 32'h24232221);
            check("three_done_lat", done_cyc - q_cyc[2], 1);
            if (gapmax == 0) begin
                check("three_space01", q_cyc[1] - q_cyc[0], 5);
                check("three_space12", q_cyc[2] - q_cyc[1], 5);
            end
        end
        check("three_ready_in_write", br_viol, 0);
        @(negedge clk);
        check("three_done_count", done_cnt - d0, 1);
        check("three_busy_after", busy, 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   d0;
        int   seq_err;

        vecs[0] = '{8'h13, 8'h05, 8'h50, 8'h00, 32'h00500513};
        vecs[1] = '{8'hef, 8'hbe, 8'had, 8'hde, 32'hdeadbeef};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        vecs[3] = '{8'hff, 8'hff, 8'hff, 8'hff, 32'hffffffff};
        vecs[4] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};

        repeat (2) @(negedge clk);
        check("rst_we", WE, 0);
        check("rst_wa", WA, 0);
        check("rst_wd", WD, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            clear_log();
            d0 = done_cnt;
            do_start(1);
            check("vec_busy_on_start", busy, 1);
            send_byte(vecs[i].b0, 0);
            send_byte(vecs[i].b1, 0);
            send_byte(vecs[i].b2, 0);
            send_byte(vecs[i].b3, 0);
            wait_done(d0);
            check("vec_we_count", q_wa.size(), 1);
            if (q_wa.size() == 1) begin
                check("vec_wa", q_wa[0], 0);
                check("vec_wd", q_wd[0], vecs[i].wd);
                check("vec_done_lat", done_cyc - q_cyc[0], 1);
            end
            @(negedge clk);
            check("vec_busy_after", busy, 0);
            check("vec_done_pulse", done, 0);
        end

        run_three(0);
        run_three(3);

        clear_log();
        d0 = done_cnt;
        do_start(0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 1);
        @(negedge clk);
        check("zero_done_off", done, 0);
        check("zero_busy_off", busy, 0);
        check("zero_no_we", q_wa.size(), 0);

        clear_log();
        d0 = done_cnt;
        do_start(2);
        send_byte(8'haa, 0);
        send_byte(8'hbb, 0);
        send_byte(8'hcc, 0);
        send_byte(8'hdd, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        repeat (8) @(negedge clk);
        check("abort_we_count", q_wa.size(), 1);
        if (q_wa.size() == 1) check("abort_wd0", q_wd[0], 32'hddccbbaa);
        check("abort_no_done", done_cnt - d0, 0);

        clear_log();
        d0 = done_cnt;
        do_start(1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        wait_done(d0);
        check("post_abort_count", q_wa.size(), 1);
        if (q_wa.size() == 1) begin
            check("post_abort_wa", q_wa[0], 0);
            check("post_abort_wd", q_wd[0], 32'h44332211);
        end
        @(negedge clk);

        clear_log();
        d0 = done_cnt;
        do_start(1);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        send_byte(8'h77, 0);
        byte_valid = 1'b1;
        byte_data  = 8'h88;
        abort      = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_last_no_we", q_wa.size(), 0);
        check("abort_last_busy", busy, 0);
        check("abort_last_no_done", done_cnt - d0, 0);

        clear_log();
        d0 = done_cnt;
        do_start(2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", byte_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_wd", WD, 0);
        check("arst_wa", WA, 0);
        check("arst_we", WE, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_no_we", q_wa.size(), 0);
        check("arst_no_done", done_cnt - d0, 0);
        check("arst_idle_busy", busy, 0);

        clear_log();
        d0 = done_cnt;
        do_start(256);
        for (int w = 0; w < 256; w++)
            for (int k = 0; k < 4; k++)
                send_byte(8'(w + k), 0);
        wait_done(d0);
        check("full_we_count", q_wa.size(), 256);
        seq_err = 0;
        for (int w = 0; w < q_wa.size(); w++) begin
            if (q_wa[w] !== AW'(w)) seq_err++;
            if (q_wd[w] !== {8'(w + 3), 8'(w + 2), 8'(w + 1), 8'(w)}) seq_err++;
        end
        check("full_seq_errors", seq_err, 0);
        if (q_wa.size() > 0) begin
            check("full_last_wa", q_wa[q_wa.size()-1], 8'hff);
            check("full_last_wd", q_wd[q_wd.size()-1], 32'h020100ff);
        end
        @(negedge clk);
        check("full_done_count", done_cnt - d0, 1);
        check("full_busy_after", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
